// File: rtl/wgt_load_ctrl.sv
// Weight-load sequencer: fetches a KROWS x KCOLS kernel from weight SRAM row-major
// and steers each returned word into the matching row shift buffer.
module wgt_load_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int KROWS  = 3,
  parameter int KCOLS  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic                     abort,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_gnt,
  input  logic signed [DATA_W-1:0] mem_rdata,
  output logic signed [DATA_W-1:0] wgt_input,
  output logic [KROWS-1:0]         wgt_read,
  output logic                     wgt_valid,
  input  logic                     wgt_consume,
  output logic                     busy,
  output logic                     done
);

  localparam int RW = (KROWS > 1) ? $clog2(KROWS) : 1;
  localparam int CW = (KCOLS > 1) ? $clog2(KCOLS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base, base_nxt;
  logic [RW-1:0]     row, row_nxt;
  logic [CW-1:0]     col, col_nxt;
  logic [KROWS-1:0]  rd, rd_nxt;
  logic              done_r, done_nxt;
  logic              accept;

  // Columns are fetched high to low so column 0 is the last word shifted in.
  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] b,
                                                   input logic [RW-1:0] r,
                                                   input logic [CW-1:0] c);
    return b + ADDR_W'(r) * ADDR_W'(KCOLS) + ADDR_W'(KCOLS - 1) - ADDR_W'(c);
  endfunction

  assign mem_req   = (state == FETCH);
  assign mem_addr  = mem_req ? fetch_addr(base, row, col) : '0;
  assign accept    = mem_req && mem_gnt;
  assign wgt_input = mem_rdata;
  assign wgt_read  = rd;
  assign wgt_valid = (state == READY);
  assign busy      = (state == FETCH) || (state == DRAIN);
  assign done      = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base   <= '0;
      row    <= '0;
      col    <= '0;
      rd     <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      base   <= base_nxt;
      row    <= row_nxt;
      col    <= col_nxt;
      rd     <= rd_nxt;
      done_r <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    row_nxt   = row;
    col_nxt   = col;
    rd_nxt    = '0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = FETCH;
          base_nxt  = base_addr;
          row_nxt   = '0;
          col_nxt   = '0;
        end
      end
      FETCH: begin
        // Abort also drops the shift for a grant accepted in the same cycle.
        if (abort) begin
          state_nxt = IDLE;
          row_nxt   = '0;
          col_nxt   = '0;
        end else if (accept) begin
          rd_nxt = KROWS'(1) << row;
          if (col == CW'(KCOLS - 1)) begin
            col_nxt = '0;
            if (row == RW'(KROWS - 1)) begin
              row_nxt   = '0;
              state_nxt = DRAIN;
            end else begin
              row_nxt = row + RW'(1);
            end
          end else begin
            col_nxt = col + CW'(1);
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = READY;
          done_nxt  = 1'b1;
        end
      end
      READY: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (start) begin
          state_nxt = FETCH;
          base_nxt  = base_addr;
          row_nxt   = '0;
          col_nxt   = '0;
        end else if (wgt_consume) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
